// File: rtl/shift16_seq_if.sv
// Request/response bundle for the iterative 16-bit shifter.
// master = requester/consumer side, slave = shifter side.
interface shift16_seq_if;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] in;
   logic [3:0]  cnt;
   logic [1:0]  op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] out;
   logic        busy;

   modport master (
      output req_valid, in, cnt, op, rsp_ready,
      input  req_ready, rsp_valid, out, busy
   );

   modport slave (
      input  req_valid, in, cnt, op, rsp_ready,
      output req_ready, rsp_valid, out, busy
   );
endinterface

// File: rtl/shift16_seq.sv
// Iterative 16-bit shifter (ROL/SLL/ROR/ASR), one bit per SHIFT cycle.
// Define SHIFT16_SEQ_STEP4_EN to take 4-bit steps while at least 4 remain.
module shift16_seq (
   input  logic          clk,
   input  logic          rst,
   shift16_seq_if.slave  bus
);

   localparam logic [1:0] st_idle  = 2'd0;
   localparam logic [1:0] st_shift = 2'd1;
   localparam logic [1:0] st_done  = 2'd2;

   localparam logic [1:0] op_rol = 2'd0;
   localparam logic [1:0] op_sll = 2'd1;
   localparam logic [1:0] op_ror = 2'd2;
   localparam logic [1:0] op_asr = 2'd3;

   logic [1:0]  state, state_d;
   logic [15:0] data, data_d;
   logic [1:0]  op_r, op_d;
   logic [3:0]  remaining, rem_d;

   function automatic logic [15:0] step1(input logic [15:0] d, input logic [1:0] o);
      logic [15:0] r;
      case (o)
         op_rol:  r = {d[14:0], d[15]};
         op_sll:  r = {d[14:0], 1'b0};
         op_ror:  r = {d[0], d[15:1]};
         default: r = {d[15], d[15:1]};
      endcase
      return r;
   endfunction

`ifdef SHIFT16_SEQ_STEP4_EN
   function automatic logic [15:0] step4(input logic [15:0] d, input logic [1:0] o);
      logic [15:0] r;
      case (o)
         op_rol:  r = {d[11:0], d[15:12]};
         op_sll:  r = {d[11:0], 4'b0000};
         op_ror:  r = {d[3:0], d[15:4]};
         default: r = {{4{d[15]}}, d[15:4]};
      endcase
      return r;
   endfunction
`endif

   always_comb begin
      state_d = state;
      data_d  = data;
      op_d    = op_r;
      rem_d   = remaining;
      case (state)
         st_idle: begin
            if (bus.req_valid) begin
               data_d  = bus.in;
               op_d    = bus.op;
               rem_d   = bus.cnt;
               state_d = (bus.cnt == 4'd0) ? st_done : st_shift;
            end
         end
         st_shift: begin
`ifdef SHIFT16_SEQ_STEP4_EN
            if (remaining >= 4'd4) begin
               data_d = step4(data, op_r);
               rem_d  = remaining - 4'd4;
            end else begin
               data_d = step1(data, op_r);
               rem_d  = remaining - 4'd1;
            end
`else
            data_d = step1(data, op_r);
            rem_d  = remaining - 4'd1;
`endif
            if (rem_d == 4'd0) begin
               state_d = st_done;
            end
         end
         st_done: begin
            // Response held until consumed; no new accept in this cycle.
            if (bus.rsp_ready) begin
               state_d = st_idle;
            end
         end
         default: state_d = st_idle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= st_idle;
         data      <= 16'h0000;
         op_r      <= 2'd0;
         remaining <= 4'd0;
      end else begin
         state     <= state_d;
         data      <= data_d;
         op_r      <= op_d;
         remaining <= rem_d;
      end
   end

   // Outputs decode from state only, so reset forces them without a clock edge.
   always_comb begin
      bus.req_ready = (state == st_idle);
      bus.busy      = (state != st_idle);
      bus.rsp_valid = (state == st_done);
      bus.out       = (state == st_done) ? data : 16'h0000;
   end

endmodule

// File: tb/tb_shift16_seq.sv
// Self-checking bench for shift16_seq: latency-level reference model checked
// every cycle, plus directed literal cases and a randomized sweep.
module tb_shift16_seq;

   logic clk = 1'b0;
   logic rst = 1'b0;
   bit   chk_en = 1'b0;

   shift16_seq_if bif ();

   shift16_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference result straight from the operation definitions.
   function automatic logic [15:0] ref_shift(input logic [15:0] x, input logic [1:0] o,
                                             input logic [3:0] c);
      int unsigned v;
      int unsigned k;
      int unsigned r;
      int          s;
      v = x;
      k = c;
      s = int'($signed(x));
      case (o)
         2'd0:    r = (v << k) | (v >> (16 - k));
         2'd1:    r = v << k;
         2'd2:    r = (v >> k) | (v << (16 - k));
         default: r = s >>> k;
      endcase
      return r[15:0];
   endfunction

   // Edges from the accept edge (inclusive) to the edge raising rsp_valid.
   function automatic int ref_lat(input logic [3:0] c);
      int k;
      k = int'(c);
`ifdef SHIFT16_SEQ_STEP4_EN
      return k / 4 + k % 4 + 1;
`else
      return k + 1;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: idle / waiting out a latency / holding a result.
   int          m_phase = 0;
   int          m_left  = 0;
   logic [15:0] m_res   = 16'h0000;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase <= 0;
         m_left  <= 0;
      end else begin
         case (m_phase)
            0: if (bif.req_valid) begin
               m_res <= ref_shift(bif.in, bif.op, bif.cnt);
               if (ref_lat(bif.cnt) == 1) begin
                  m_phase <= 2;
               end else begin
                  m_phase <= 1;
                  m_left  <= ref_lat(bif.cnt) - 1;
               end
            end
            1: begin
               if (m_left == 1) m_phase <= 2;
               m_left <= m_left - 1;
            end
            default: if (bif.rsp_ready) m_phase <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cycle", {13'd0, bif.req_ready, bif.busy, bif.rsp_valid, bif.out},
               {13'd0, m_phase == 0, m_phase != 0, m_phase == 2,
                (m_phase == 2) ? m_res : 16'h0000});
      end
   end

   // Called just after a falling edge with the DUT idle.
   task automatic do_op(input logic [15:0] x, input logic [1:0] o, input logic [3:0] c,
                        input int hold, input bit req_in_hold,
                        output logic [15:0] res, output int lat);
      bif.in        = x;
      bif.op        = o;
      bif.cnt       = c;
      bif.req_valid = 1'b1;
      bif.rsp_ready = 1'b0;
      lat = 0;
      res = 16'h0000;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            bif.in        = 16'($urandom);
            bif.op        = 2'($urandom);
            bif.cnt       = 4'($urandom);
            bif.req_valid = 1'($urandom);
         end
      end while (!bif.rsp_valid && lat < 40);
      if (!bif.rsp_valid) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout: rsp_valid not seen within %0d edges", lat);
         bif.req_valid = 1'b0;
         return;
      end
      res = bif.out;
      for (int i = 0; i < hold; i++) begin
         bif.req_valid = req_in_hold;
         @(negedge clk);
         check("hold", {15'd0, bif.rsp_valid, bif.out}, {15'd0, 1'b1, res});
      end
      bif.req_valid = 1'b0;
      bif.rsp_ready = 1'b1;
      @(negedge clk);
      bif.rsp_ready = 1'b0;
   endtask

   task automatic directed(input string name, input logic [15:0] x, input logic [1:0] o,
                           input logic [3:0] c, input logic [15:0] exp_out,
                           input int exp_lat, input int hold);
      logic [15:0] res;
      int          lat;
      do_op(x, o, c, hold, 1'b1, res, lat);
      check({name, "_out"}, {16'd0, res}, {16'd0, exp_out});
      check({name, "_lat"}, lat, exp_lat);
   endtask

   initial begin
      logic [15:0] res, x;
      logic [1:0]  o;
      logic [3:0]  c;
      int          lat;
      int          step4;
`ifdef SHIFT16_SEQ_STEP4_EN
      step4 = 1;
`else
      step4 = 0;
`endif
      bif.req_valid = 1'b0;
      bif.rsp_ready = 1'b0;
      bif.in        = 16'h0000;
      bif.cnt       = 4'd0;
      bif.op        = 2'd0;
      #1 rst = 1'b1;
      #1 check("reset", {13'd0, bif.req_ready, bif.busy, bif.rsp_valid, bif.out},
               {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
      chk_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      directed("rol_00ea_4", 16'h00EA, 2'd0, 4'd4, 16'h0EA0, step4 ? 2 : 5, 0);
      directed("asr_fa7b_4", 16'hFA7B, 2'd3, 4'd4, 16'hFFA7, step4 ? 2 : 5, 0);
      directed("sll_0018_12", 16'h0018, 2'd1, 4'd12, 16'h8000, step4 ? 4 : 13, 0);
      directed("ror_3e15_8", 16'h3E15, 2'd2, 4'd8, 16'h153E, step4 ? 3 : 9, 0);
      for (int i = 0; i < 4; i++) begin
         o = 2'(i);
         directed("cnt0", 16'h3E15, o, 4'd0, 16'h3E15, 1, 0);
      end
      // Long stall in DONE with req_valid asserted, then back-to-back request.
      directed("stall", 16'h8001, 2'd2, 4'd1, 16'hC000, 2, 5);
      directed("after_stall", 16'h8001, 2'd3, 4'd3, 16'hF000, step4 ? 4 : 4, 0);

      // Abort mid-SHIFT: accept, three shift edges, then async reset between edges.
      bif.in        = 16'h1234;
      bif.op        = 2'd0;
      bif.cnt       = 4'd15;
      bif.req_valid = 1'b1;
      @(negedge clk);
      bif.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1 check("abort", {13'd0, bif.req_ready, bif.busy, bif.rsp_valid, bif.out},
               {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      directed("post_rst", 16'h0001, 2'd1, 4'd15, 16'h8000, step4 ? 7 : 16, 0);

      for (int i = 0; i < 1000; i++) begin
         x = 16'($urandom);
         o = 2'($urandom);
         c = 4'($urandom);
         do_op(x, o, c, int'($urandom_range(0, 2)), 1'($urandom), res, lat);
         check("rand_out", {16'd0, res}, {16'd0, ref_shift(x, o, c)});
         check("rand_lat", lat, ref_lat(c));
      end

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
